// File: rtl/nic_mac_seq_pkg.sv
// nic_mac_seq_pkg: state codes, status word layout and field widths for the MAC reset sequencer
package nic_mac_seq_pkg;
  typedef enum logic [2:0] {
    ST_ASSERT     = 3'd0,
    ST_PHY_HOLD   = 3'd1,
    ST_PHY_SETTLE = 3'd2,
    ST_MAC_WAIT   = 3'd3,
    ST_RUNNING    = 3'd4,
    ST_FAULT      = 3'd5
  } state_e;
  localparam int FAULT_CNT_W = 4;
  localparam int ST_LSB = 0;
  localparam int ST_MSB = 2;
  localparam int LOCK_BIT = 3;
  localparam int FC_LSB = 4;
  localparam int FC_MSB = 7;
  function automatic logic [7:0] status_word(state_e s, logic lock, logic [FAULT_CNT_W-1:0] fc);
    logic [7:0] w;
    w = '0;
    w[ST_MSB:ST_LSB] = s;
    w[LOCK_BIT] = lock;
    w[FC_MSB:FC_LSB] = fc;
    return w;
  endfunction
endpackage

// File: rtl/nic_mac_reset_sequencer_if.sv
// nic_mac_reset_sequencer_if: req/ack status pipe carrying sequencer status words
interface nic_mac_reset_sequencer_if;
  logic [7:0] data;
  logic req;
  logic ack;
  modport master(output data, output req, input ack);
  modport slave(input data, input req, output ack);
endinterface

// File: rtl/nic_sync2.sv
// nic_sync2: two-flop synchronizer, async active-low reset to 0
module nic_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff_q <= '0;
    else ff_q <= {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/nic_mac_reset_sequencer.sv
// nic_mac_reset_sequencer: ordered PHY-then-MAC reset release with lock supervision and status pipe
module nic_mac_reset_sequencer
  import nic_mac_seq_pkg::*;
#(
  parameter int PHY_RST_CYCLES      = 1000,
  parameter int PHY_SETTLE_CYCLES   = 2000,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int CNT_W               = 20
) (
  input  logic clk,
  input  logic RESET_N,
  input  logic NIC_TO_MAC_RESET_N,
  input  logic MAC_LOCKED,
  output logic PHY_RESET_N,
  output logic MAC_RESET_N,
  nic_mac_reset_sequencer_if.master MAC_STATUS_pipe
);
  localparam logic [CNT_W-1:0] PHY_LOAD    = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(PHY_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FAULT_CNT_W-1:0] fc_q, fc_d;
  logic phy_q, phy_d, mac_q, mac_d, req_q, req_d, lock_s, evt;
  logic [7:0] data_q, data_d;
  nic_sync2 u_lock_sync (.clk(clk), .rst_n(RESET_N), .d_i(MAC_LOCKED), .q_o(lock_s));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (!NIC_TO_MAC_RESET_N) begin
      state_d = ST_ASSERT;
      cnt_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          state_d = ST_PHY_HOLD;
          cnt_d = PHY_LOAD;
        end
        ST_PHY_HOLD: begin
          state_d = cnt_q == '0 ? ST_PHY_SETTLE : ST_PHY_HOLD;
          cnt_d = cnt_q == '0 ? SETTLE_LOAD : cnt_q - CNT_W'(1);
        end
        ST_PHY_SETTLE: begin
          state_d = cnt_q == '0 ? ST_MAC_WAIT : ST_PHY_SETTLE;
          cnt_d = cnt_q == '0 ? LOCK_LOAD : cnt_q - CNT_W'(1);
        end
        ST_MAC_WAIT: begin
          // lock wins over a timeout landing in the same cycle
          state_d = lock_s ? ST_RUNNING : cnt_q == '0 ? ST_FAULT : ST_MAC_WAIT;
          cnt_d = lock_s || cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
        end
        ST_RUNNING: state_d = lock_s ? ST_RUNNING : ST_FAULT;
        ST_FAULT: state_d = ST_FAULT;
        default: state_d = ST_ASSERT;
      endcase
    end
    phy_d = state_d inside {ST_PHY_SETTLE, ST_MAC_WAIT, ST_RUNNING, ST_FAULT};
    mac_d = state_d inside {ST_MAC_WAIT, ST_RUNNING};
    evt = state_d != state_q;
    fc_d = evt && state_d == ST_FAULT && fc_q != '1 ? fc_q + FAULT_CNT_W'(1) : fc_q;
    // a new event overwrites any pending word; a bare transfer retires it
    req_d = evt | (req_q & ~MAC_STATUS_pipe.ack);
    data_d = evt ? status_word(state_d, lock_s, fc_d) : data_q;
  end
  always_ff @(posedge clk or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= ST_ASSERT;
      cnt_q <= '0;
      fc_q <= '0;
      phy_q <= 1'b0;
      mac_q <= 1'b0;
      req_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fc_q <= fc_d;
      phy_q <= phy_d;
      mac_q <= mac_d;
      req_q <= req_d;
      data_q <= data_d;
    end
  assign PHY_RESET_N = phy_q;
  assign MAC_RESET_N = mac_q;
  assign MAC_STATUS_pipe.req = req_q;
  assign MAC_STATUS_pipe.data = data_q;
endmodule
